// File: rtl/sequenciador_rodadas_memoria_pkg.sv
// rtl/sequenciador_rodadas_memoria_pkg.sv - state codes and playback timing defaults for the round sequencer
package sequenciador_pkg;

  // Default playback timing at a 1 kHz clock
  localparam int LED_ON_PADRAO  = 500;
  localparam int LED_OFF_PADRAO = 250;
  localparam int CNT_W_PADRAO   = 10;

  // State codes are visible on db_estado, so they are fixed, not tool-chosen
  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    MOSTRA     = 4'h2,
    APAGA      = 4'h3,
    PROX_LED   = 4'h4,
    INICIA_JOG = 4'h5,
    ESPERA     = 4'h6,
    REGISTRA   = 4'h7,
    COMPARA    = 4'h8,
    PROX_JOG   = 4'h9,
    PROX_ROD   = 4'hA,
    FIM_GANHOU = 4'hC,
    FIM_PERDEU = 4'hD,
    FIM_TMO    = 4'hE
  } estado_t;

endpackage

// File: rtl/sequenciador_rodadas_memoria_temporizador_led.sv
// rtl/sequenciador_rodadas_memoria_temporizador_led.sv - clearable saturating up-counter with terminal-count flag
module temporizador_led #(
  parameter int CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             zera_i,
  input  logic             conta_i,
  input  logic [CNT_W-1:0] limite_i,
  output logic             fim_o
);

  localparam logic [CNT_W-1:0] MAXIMO = '1;

  logic [CNT_W-1:0] valor_q, valor_d;

  // Clear has priority; counting stops at all-ones instead of wrapping
  always_comb begin
    valor_d = valor_q;
    if (zera_i) begin
      valor_d = '0;
    end else if (conta_i && (valor_q != MAXIMO)) begin
      valor_d = valor_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim_o = (valor_q == limite_i);

endmodule

// File: rtl/sequenciador_rodadas_memoria.sv
// rtl/sequenciador_rodadas_memoria.sv - memory game round sequencer FSM; TIMEOUT_EN enables the player move timeout
module sequenciador_rodadas_memoria
  import sequenciador_pkg::*;
#(
  parameter int LED_ON_CICLOS  = LED_ON_PADRAO,
  parameter int LED_OFF_CICLOS = LED_OFF_PADRAO,
  parameter int CNT_W          = CNT_W_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igualE,
  input  logic       enderecoIgual,
  input  logic       fimS,
  input  logic       fim_timeout,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       regR,
  output logic       zeraT,
  output logic       contaT,
  output logic       controla_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       deu_timeout,
  output logic [3:0] db_estado
);

  localparam logic [CNT_W-1:0] LIMITE_ON  = CNT_W'(LED_ON_CICLOS - 1);
  localparam logic [CNT_W-1:0] LIMITE_OFF = CNT_W'(LED_OFF_CICLOS - 1);

  estado_t          estado_q, estado_d;
  logic             tmr_zera, tmr_conta, tmr_fim;
  logic [CNT_W-1:0] tmr_limite;

`ifndef TIMEOUT_EN
  logic unused_fim_timeout;
  assign unused_fim_timeout = fim_timeout;
`endif

  // Timer restarts at every state change so each visit to MOSTRA/APAGA starts from zero
  assign tmr_zera   = (estado_d != estado_q);
  assign tmr_conta  = (estado_q == MOSTRA) || (estado_q == APAGA);
  assign tmr_limite = (estado_q == MOSTRA) ? LIMITE_ON : LIMITE_OFF;

  temporizador_led #(
    .CNT_W(CNT_W)
  ) u_temporizador (
    .clk_i   (clock),
    .rst_i   (reset),
    .zera_i  (tmr_zera),
    .conta_i (tmr_conta),
    .limite_i(tmr_limite),
    .fim_o   (tmr_fim)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    estado_d      = estado_q;
    zeraE         = 1'b0;
    contaE        = 1'b0;
    zeraS         = 1'b0;
    contaS        = 1'b0;
    zeraR         = 1'b0;
    regR          = 1'b0;
    zeraT         = 1'b0;
    contaT        = 1'b0;
    controla_leds = 1'b0;
    pronto        = 1'b0;
    ganhou        = 1'b0;
    perdeu        = 1'b0;
    deu_timeout   = 1'b0;
    case (estado_q)
      INICIAL: begin
        if (jogar) estado_d = PREPARA;
      end
      PREPARA: begin
        zeraE    = 1'b1;
        zeraS    = 1'b1;
        zeraR    = 1'b1;
        zeraT    = 1'b1;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        controla_leds = 1'b1;
        if (tmr_fim) estado_d = APAGA;
      end
      APAGA: begin
        if (tmr_fim) estado_d = enderecoIgual ? INICIA_JOG : PROX_LED;
      end
      PROX_LED: begin
        contaE   = 1'b1;
        estado_d = MOSTRA;
      end
      INICIA_JOG: begin
        zeraE    = 1'b1;
        zeraT    = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
`ifdef TIMEOUT_EN
        contaT = 1'b1;
        if (tem_jogada) begin
          estado_d = REGISTRA;
        end else if (fim_timeout) begin
          estado_d = FIM_TMO;
        end
`else
        if (tem_jogada) estado_d = REGISTRA;
`endif
      end
      REGISTRA: begin
        regR     = 1'b1;
        estado_d = COMPARA;
      end
      COMPARA: begin
        if (!igualE) begin
          estado_d = FIM_PERDEU;
        end else if (!enderecoIgual) begin
          estado_d = PROX_JOG;
        end else if (fimS) begin
          estado_d = FIM_GANHOU;
        end else begin
          estado_d = PROX_ROD;
        end
      end
      PROX_JOG: begin
        contaE   = 1'b1;
        zeraT    = 1'b1;
        estado_d = ESPERA;
      end
      PROX_ROD: begin
        contaS   = 1'b1;
        zeraE    = 1'b1;
        zeraR    = 1'b1;
        estado_d = MOSTRA;
      end
      FIM_GANHOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
        if (jogar) estado_d = PREPARA;
      end
      FIM_PERDEU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
        if (jogar) estado_d = PREPARA;
      end
`ifdef TIMEOUT_EN
      FIM_TMO: begin
        deu_timeout = 1'b1;
        pronto      = 1'b1;
        if (jogar) estado_d = PREPARA;
      end
`endif
      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  assign db_estado = estado_q;

endmodule
